// File: rtl/ps2_pkg.sv
// Shared constants, sequencer states and the ASCII to set-2 scan-code lookup
// for the PS/2 keystroke transmitter.
package ps2_pkg;

  localparam logic [7:0] BREAK_PREFIX = 8'hF0;
  localparam int         FRAME_BITS   = 11;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_MAKE   = 3'd1,
    SEQ_GAP1   = 3'd2,
    SEQ_PREFIX = 3'd3,
    SEQ_GAP2   = 3'd4,
    SEQ_BREAK  = 3'd5
  } seq_state_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] code;
  } scan_t;

  // Tables are packed with entry 0 in the least significant byte.
  localparam logic [79:0] DIGIT_TBL = {
    8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E, 8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
  };

  localparam logic [207:0] LETTER_TBL = {
    8'h1A, 8'h35, 8'h22, 8'h1D, 8'h2A, 8'h3C, 8'h2C, 8'h1B, 8'h2D, 8'h15,
    8'h4D, 8'h44, 8'h31, 8'h3A, 8'h4B, 8'h42, 8'h3B, 8'h43, 8'h33, 8'h34,
    8'h2B, 8'h24, 8'h23, 8'h21, 8'h32, 8'h1C
  };

  function automatic scan_t ascii_to_scan(input logic [7:0] c);
    scan_t      s;
    logic [4:0] idx;
    s   = '{valid: 1'b0, code: 8'h00};
    idx = 5'd0;
    if (c >= 8'h30 && c <= 8'h39) begin
      idx     = 5'(c - 8'h30);
      s.valid = 1'b1;
      s.code  = DIGIT_TBL[{idx[3:0], 3'b000} +: 8];
    end else if (c >= 8'h41 && c <= 8'h5A) begin
      idx     = 5'(c - 8'h41);
      s.valid = 1'b1;
      s.code  = LETTER_TBL[{idx, 3'b000} +: 8];
    end else if (c >= 8'h61 && c <= 8'h7A) begin
      idx     = 5'(c - 8'h61);
      s.valid = 1'b1;
      s.code  = LETTER_TBL[{idx, 3'b000} +: 8];
    end
    return s;
  endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Single-byte PS/2 device serializer: start, 8 data bits LSB first, odd
// parity, stop; each bit is a HIGH half-period followed by a LOW half-period.
module ps2_frame_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       start,
  input  logic [7:0] tx_byte,
  output logic       done,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam int             PW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]  PHASE_LAST = PW'(CLK_DIV - 1);
  localparam logic [3:0]     BIT_LAST   = 4'(FRAME_BITS - 1);

  logic          active_reg;
  logic          low_reg;
  logic [PW-1:0] phase_reg;
  logic [3:0]    bit_reg;
  logic [9:0]    shift_reg;
  logic          pclk_reg;
  logic          pdata_reg;
  logic          phase_end;

  assign phase_end = (phase_reg == PHASE_LAST);
  // Asserted during the final cycle of the stop bit's LOW phase.
  assign done      = active_reg && low_reg && phase_end && (bit_reg == BIT_LAST);
  assign ps2_clk   = pclk_reg;
  assign ps2_data  = pdata_reg;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      active_reg <= 1'b0;
      low_reg    <= 1'b0;
      phase_reg  <= '0;
      bit_reg    <= 4'd0;
      shift_reg  <= 10'h3FF;
      pclk_reg   <= 1'b1;
      pdata_reg  <= 1'b1;
    end else if (start) begin
      active_reg <= 1'b1;
      low_reg    <= 1'b0;
      phase_reg  <= '0;
      bit_reg    <= 4'd0;
      shift_reg  <= {1'b1, ~^tx_byte, tx_byte};
      pclk_reg   <= 1'b1;
      pdata_reg  <= 1'b0;
    end else if (active_reg) begin
      if (!phase_end) begin
        phase_reg <= phase_reg + 1'b1;
      end else begin
        phase_reg <= '0;
        if (!low_reg) begin
          low_reg  <= 1'b1;
          pclk_reg <= 1'b0;
        end else if (bit_reg == BIT_LAST) begin
          active_reg <= 1'b0;
          low_reg    <= 1'b0;
          bit_reg    <= 4'd0;
          pclk_reg   <= 1'b1;
          pdata_reg  <= 1'b1;
        end else begin
          // Data only moves at the start of a HIGH phase.
          low_reg   <= 1'b0;
          bit_reg   <= bit_reg + 1'b1;
          pclk_reg  <= 1'b1;
          pdata_reg <= shift_reg[0];
          shift_reg <= {1'b1, shift_reg[9:1]};
        end
      end
    end
  end

endmodule

// File: rtl/ps2_key_sender.sv
// Keyboard-side PS/2 transmitter: accepts one ASCII character and plays the
// full keystroke (make, F0, break) with idle gaps between frames.
module ps2_key_sender
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       ascii_valid,
  input  logic [7:0] ascii,
  output logic       ascii_ready,
  output logic       busy,
  output logic       unknown,
  output logic       ps2_clk,
  output logic       ps2_data
);

  localparam logic [2:0] S_IDLE   = SEQ_IDLE;
  localparam logic [2:0] S_MAKE   = SEQ_MAKE;
  localparam logic [2:0] S_GAP1   = SEQ_GAP1;
  localparam logic [2:0] S_PREFIX = SEQ_PREFIX;
  localparam logic [2:0] S_GAP2   = SEQ_GAP2;
  localparam logic [2:0] S_BREAK  = SEQ_BREAK;

  localparam int            GW       = $clog2(GAP_CYCLES + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  logic [2:0]    state_reg;
  logic [GW-1:0] gap_reg;
  logic [7:0]    code_reg;
  logic          ready_reg;
  logic          busy_reg;
  logic          unknown_reg;

  scan_t      map;
  logic       accept;
  logic       gap_end;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       frame_done;

  assign map         = ascii_to_scan(ascii);
  assign accept      = ascii_valid && ready_reg;
  assign gap_end     = (gap_reg == GAP_LAST);
  assign ascii_ready = ready_reg;
  assign busy        = busy_reg;
  assign unknown     = unknown_reg;

  // The make frame starts on the accepting edge so the start bit is visible
  // the very next cycle; later frames start on the last gap cycle.
  always_comb begin
    tx_start = 1'b0;
    tx_byte  = code_reg;
    case (state_reg)
      S_IDLE: begin
        tx_start = accept && map.valid;
        tx_byte  = map.code;
      end
      S_GAP1: begin
        tx_start = gap_end;
        tx_byte  = BREAK_PREFIX;
      end
      S_GAP2: begin
        tx_start = gap_end;
        tx_byte  = code_reg;
      end
      default: begin
        tx_start = 1'b0;
        tx_byte  = code_reg;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg   <= S_IDLE;
      gap_reg     <= '0;
      code_reg    <= 8'h00;
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      unknown_reg <= 1'b0;
    end else begin
      unknown_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            if (map.valid) begin
              state_reg <= S_MAKE;
              code_reg  <= map.code;
              ready_reg <= 1'b0;
              busy_reg  <= 1'b1;
            end else begin
              unknown_reg <= 1'b1;
            end
          end
        end
        S_MAKE: begin
          if (frame_done) state_reg <= S_GAP1;
        end
        S_GAP1: begin
          if (gap_end) begin
            state_reg <= S_PREFIX;
            gap_reg   <= '0;
          end else begin
            gap_reg <= gap_reg + 1'b1;
          end
        end
        S_PREFIX: begin
          if (frame_done) state_reg <= S_GAP2;
        end
        S_GAP2: begin
          if (gap_end) begin
            state_reg <= S_BREAK;
            gap_reg   <= '0;
          end else begin
            gap_reg <= gap_reg + 1'b1;
          end
        end
        S_BREAK: begin
          if (frame_done) begin
            state_reg <= S_IDLE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          gap_reg   <= '0;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  ps2_frame_tx #(
    .CLK_DIV (CLK_DIV)
  ) u_frame_tx (
    .clk      (clk),
    .clrn     (clrn),
    .start    (tx_start),
    .tx_byte  (tx_byte),
    .done     (frame_done),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

endmodule

// File: tb/tb_ps2_key_sender.sv
// Randomized bench for ps2_key_sender: a falling-edge PS/2 host decodes the
// frames and compares them with a table-driven keystroke model.
module tb_ps2_key_sender;

  localparam int CLK_DIV    = 4;
  localparam int GAP_CYCLES = 16;
  localparam int FRAME_CYC  = 22 * CLK_DIV;
  localparam int BUSY_CYC   = 66 * CLK_DIV + 2 * GAP_CYCLES;
  localparam int STRIDE     = FRAME_CYC + GAP_CYCLES;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic       ascii_valid = 1'b0;
  logic [7:0] ascii = 8'h00;
  logic       ascii_ready;
  logic       busy;
  logic       unknown;
  logic       ps2_clk;
  logic       ps2_data;

  ps2_key_sender #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP_CYCLES)
  ) dut (
    .clk         (clk),
    .clrn        (clrn),
    .ascii_valid (ascii_valid),
    .ascii       (ascii),
    .ascii_ready (ascii_ready),
    .busy        (busy),
    .unknown     (unknown),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference scan-code tables, straight from the character map.
  int dig_tbl[10] = '{'h45, 'h16, 'h1E, 'h26, 'h25, 'h2E, 'h36, 'h3D, 'h3E, 'h46};
  int let_tbl[26] = '{'h1C, 'h32, 'h21, 'h23, 'h24, 'h2B, 'h34, 'h33, 'h43, 'h3B,
                      'h42, 'h4B, 'h3A, 'h31, 'h44, 'h4D, 'h15, 'h2D, 'h1B, 'h2C,
                      'h3C, 'h2A, 'h1D, 'h22, 'h35, 'h1A};

  function automatic int exp_code(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return dig_tbl[c - 8'h30];
    if (c >= 8'h41 && c <= 8'h5A) return let_tbl[c - 8'h41];
    if (c >= 8'h61 && c <= 8'h7A) return let_tbl[c - 8'h61];
    return -1;
  endfunction

  // Host-side monitor: frame starts, falling-edge bit capture, decoded bytes.
  int         rx_q[$];
  int         fstart_q[$];
  int         fall_cnt = 0;
  int         low_viol = 0;
  int         nbits = 0;
  logic [10:0] bits = '0;
  logic       in_frame = 1'b0;
  logic       prev_pclk = 1'b1;
  logic       prev_pdata = 1'b1;

  initial begin
    forever begin
      @(negedge clk);
      if (!clrn) begin
        nbits      = 0;
        in_frame   = 1'b0;
        prev_pclk  = 1'b1;
        prev_pdata = 1'b1;
      end else begin
        if (!ps2_clk && prev_pclk == 1'b0 && ps2_data != prev_pdata) low_viol++;
        if (!in_frame && ps2_clk && !ps2_data) begin
          in_frame = 1'b1;
          fstart_q.push_back(cyc);
        end
        if (prev_pclk && !ps2_clk) begin
          fall_cnt++;
          bits[nbits] = ps2_data;
          nbits++;
          if (nbits == 11) begin
            if (bits[0] == 1'b0 && bits[10] == 1'b1 && $countones(bits[9:1]) % 2 == 1)
              rx_q.push_back(int'(bits[8:1]));
            else
              rx_q.push_back(256 + int'(bits[8:1]));
            nbits    = 0;
            in_frame = 1'b0;
          end
        end
        prev_pclk  = ps2_clk;
        prev_pdata = ps2_data;
      end
    end
  end

  task automatic clear_mon();
    rx_q.delete();
    fstart_q.delete();
  endtask

  task automatic check_keystroke(input string tag, input int code, input int t0);
    int exp_b[3];
    exp_b[0] = code;
    exp_b[1] = 'hF0;
    exp_b[2] = code;
    for (int k = 0; k < 3; k++) begin
      if (rx_q.size() > 0) check_eq({tag, "_byte"}, rx_q.pop_front(), exp_b[k]);
      else check_eq({tag, "_byte_missing"}, -1, exp_b[k]);
      if (fstart_q.size() > 0) check_eq({tag, "_start_cyc"}, fstart_q.pop_front(), t0 + k * STRIDE);
      else check_eq({tag, "_start_missing"}, -1, t0 + k * STRIDE);
    end
  endtask

  // One keystroke; optionally drives a competing character mid-keystroke.
  task automatic do_key(input logic [7:0] c, input bit distract);
    int code, t_acc, nbusy, w, f0;
    code = exp_code(c);
    clear_mon();
    f0 = fall_cnt;
    w = 0;
    while (!ascii_ready && w < 1000) begin
      @(negedge clk);
      w++;
    end
    check_eq("ready_before_key", int'(ascii_ready), 1);
    check_eq("lines_idle", int'({ps2_clk, ps2_data}), 3);
    ascii       = c;
    ascii_valid = 1'b1;
    @(negedge clk);
    t_acc       = cyc;
    ascii_valid = 1'b0;
    check_eq("unknown_after_accept", int'(unknown), (code < 0) ? 1 : 0);
    check_eq("ready_after_accept", int'(ascii_ready), (code < 0) ? 1 : 0);
    if (code >= 0) check_eq("start_bit_next_cycle", int'({ps2_clk, ps2_data}), 2);
    nbusy = 0;
    while (busy && nbusy < 2000) begin
      nbusy++;
      @(negedge clk);
      if (distract && nbusy == 40) begin
        ascii       = 8'($urandom_range(8'h30, 8'h7A));
        ascii_valid = 1'b1;
      end
      if (nbusy == 60) ascii_valid = 1'b0;
    end
    ascii_valid = 1'b0;
    check_eq("busy_cycles", nbusy, (code < 0) ? 0 : BUSY_CYC);
    @(negedge clk);
    check_eq("unknown_cleared", int'(unknown), 0);
    check_eq("ready_after_key", int'(ascii_ready), 1);
    if (code >= 0) begin
      check_keystroke("key", code, t_acc);
    end else begin
      check_eq("unknown_no_edges", fall_cnt - f0, 0);
      check_eq("unknown_no_frames", fstart_q.size() + rx_q.size(), 0);
    end
    $display("key 0x%02h code %0d distract %0d accepted at cycle %0d busy %0d",
             c, code, distract, t_acc, nbusy);
  endtask

  initial begin
    int t_acc, w, f0;
    logic [7:0] c;
    // Power-on reset
    repeat (3) @(negedge clk);
    check_eq("reset_ps2_clk", int'(ps2_clk), 1);
    check_eq("reset_ps2_data", int'(ps2_data), 1);
    check_eq("reset_ready", int'(ascii_ready), 1);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_unknown", int'(unknown), 0);
    #2 clrn = 1'b1;
    repeat (3) @(negedge clk);

    // Directed keys
    do_key(8'h41, 1'b0);
    do_key(8'h7A, 1'b0);
    do_key(8'h21, 1'b0);
    do_key(8'h42, 1'b1);

    // Back-to-back: hold valid, swap '0' for '9' after the first acceptance
    clear_mon();
    ascii       = 8'h30;
    ascii_valid = 1'b1;
    @(negedge clk);
    t_acc = cyc;
    ascii = 8'h39;
    w = 0;
    while (fstart_q.size() < 4 && w < 1500) begin
      @(negedge clk);
      w++;
    end
    ascii_valid = 1'b0;
    check_eq("b2b_second_start", (fstart_q.size() >= 4) ? fstart_q[3] - t_acc : -1, 297);
    w = 0;
    while (busy && w < 1000) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    check_keystroke("b2b_first", 'h45, t_acc);
    check_keystroke("b2b_second", 'h46, t_acc + 297);
    $display("key pair 0x30/0x39 accepted from cycle %0d", t_acc);

    // Reset during bit 4 of the make frame
    clear_mon();
    f0          = fall_cnt;
    ascii       = 8'h41;
    ascii_valid = 1'b1;
    @(negedge clk);
    ascii_valid = 1'b0;
    w = 0;
    while (fall_cnt - f0 < 5 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check_eq("rst_reached_bit4", fall_cnt - f0, 5);
    #2 clrn = 1'b0;
    #1;
    check_eq("rst_mid_ps2_clk", int'(ps2_clk), 1);
    check_eq("rst_mid_ps2_data", int'(ps2_data), 1);
    check_eq("rst_mid_ready", int'(ascii_ready), 1);
    check_eq("rst_mid_busy", int'(busy), 0);
    repeat (2) @(negedge clk);
    #2 clrn = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("rst_no_more_edges", fall_cnt - f0, 5);
    check_eq("rst_no_frames", rx_q.size(), 0);
    check_eq("rst_idle_lines", int'({ps2_clk, ps2_data, busy}), 6);
    $display("reset mid-frame at cycle %0d", cyc);

    // Randomized keys
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 3))
        0:       c = 8'($urandom_range(8'h30, 8'h39));
        1:       c = 8'($urandom_range(8'h41, 8'h5A));
        2:       c = 8'($urandom_range(8'h61, 8'h7A));
        default: c = 8'($urandom_range(0, 255));
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_key(c, 1'($urandom_range(0, 1)));
    end

    check_eq("data_stable_low_phase", low_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ps2_key_sender.md
Name: ps2_key_sender

Overview:
- Device-side PS/2 keyboard transmitter: the inverse of the keyboard scan-code-to-ASCII path.
- Accepts one ASCII character per valid/ready handshake and maps it to a set-2 scan code.
- Drives a full keystroke on ps2_clk/ps2_data, exactly as a real keyboard would: make code, then F0 prefix, then break code.
- Used as a stimulus source for the keyboard receiver in simulation and on-board loopback.

Parameters:
- CLK_DIV, 4: system clock cycles per PS/2 clock half-period (must be >= 2).
- GAP_CYCLES, 16: idle cycles, with both lines high, between consecutive frames of one keystroke.

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- ascii_valid  in  1  ascii holds a character to send
- ascii  in  8  ASCII character
- ascii_ready  out  1  block can accept a character
- busy  out  1  keystroke in progress
- unknown  out  1  one-cycle pulse: accepted character has no scan code and is dropped
- ps2_clk  out  1  PS/2 clock, device-driven
- ps2_data  out  1  PS/2 data, device-driven

Behaviour:
- Reset (asynchronous, clrn=0) values:
  - ps2_clk=1, ps2_data=1, ascii_ready=1, busy=0, unknown=0.
  - The FSM returns to IDLE immediately, even mid-frame; the partial frame is abandoned.
- Handshake:
  - A character is accepted on the rising edge where ascii_valid && ascii_ready.
  - ascii is sampled only at that edge.
  - ascii_ready is 0 from the next cycle until the keystroke completes.
- Mapping (combinational lookup, registered at acceptance):
  - '0'..'9' (0x30-0x39) -> 45,16,1E,26,25,2E,36,3D,3E,46.
  - 'A'..'Z' (0x41-0x5A) and 'a'..'z' (0x61-0x7A) -> 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A.
  - Any other code: unknown=1 for the cycle after acceptance; no frame is sent; ascii_ready returns to 1 that same cycle.
- Sequencer FSM:
  - IDLE -> MAKE -> GAP1 -> PREFIX -> GAP2 -> BREAK -> IDLE.
  - MAKE sends the code; PREFIX sends 0xF0; BREAK sends the code again.
  - GAP states hold both lines at 1 for GAP_CYCLES cycles.
- Frame (11 bits): start 0, data[0..7] LSB first, odd parity (~^data), stop 1.
- Bit timing:
  - Each bit has a HIGH phase (ps2_clk=1, CLK_DIV cycles) followed by a LOW phase (ps2_clk=0, CLK_DIV cycles).
  - ps2_data updates only on the first cycle of a HIGH phase and is stable through the LOW phase, so the host samples on the falling edge.
  - Frame length is 22*CLK_DIV cycles.
  - After the stop bit's LOW phase, both lines return to 1.
- Latency:
  - The start bit (ps2_data=0) appears on the cycle after acceptance.
  - busy=1 for exactly 66*CLK_DIV + 2*GAP_CYCLES cycles after acceptance.
  - ascii_ready=1 and busy=0 on the next cycle.
- Simultaneous events:
  - ascii_valid held high with a new character during busy is ignored; it is not queued.
  - Back-to-back acceptance is legal the cycle ready rises.
- Counters:
  - Phase counter is ceil(log2(CLK_DIV)) bits.
  - Bit index is 0..10.
  - Gap counter is ceil(log2(GAP_CYCLES+1)) bits.
  - No wrap occurs inside a frame; all counters clear on state exit.
- Outputs are driven from flops only (glitch-free ps2_clk).

Decomposition:
- Package ps2_pkg:
  - BREAK_PREFIX=8'hF0
  - FRAME_BITS=11
  - sequencer state enum
  - ascii-to-scancode function (returns valid flag + code)
- Sub-module ps2_frame_tx: single-byte serializer.
  - Inputs: start, byte.
  - Outputs: done pulse, ps2_clk, ps2_data.
  - Owns phase/bit counters and parity.
- The top owns the handshake, mapping, gap counter and sequencer.

Test Plan (CLK_DIV=4, GAP_CYCLES=16):
- Reset mid-frame: assert clrn=0 during MAKE bit 4 -> ps2_clk=1, ps2_data=1, ascii_ready=1 within the same cycle; after release, idle with no further edges.
- Send 'A' (0x41): falling-edge-sampled bits give three frames.
  - Frame 1: 0,0,0,1,1,1,0,0,0,P=0,1 (0x1C).
  - Frame 2: 0xF0 with P=1.
  - Frame 3: 0x1C again.
  - Gaps between frames are exactly 16 cycles of idle.
  - busy lasts 296 cycles.
- Send 'z' (0x7A) -> frames 1A, F0, 1A; parity bits 0,1,0.
- Send '!' (0x21) -> unknown pulses for 1 cycle; no ps2_clk edge; ascii_ready=1 the next cycle.
- Hold ascii_valid with '0' then '9' back-to-back -> 45/F0/45 then 46/F0/46; second start bit 297 cycles after first acceptance.
- Assert ascii_valid mid-keystroke with another character -> ignored; the ps2 waveform is identical to the single-key case.
